// File: rtl/eth_in_fifo.sv
// Ingress store-and-forward frame FIFO in front of a switch input port.
// Words of a frame become visible to the output stage only after the frame's
// eop word is written. Overflowing or malformed frames are discarded.
// Optional macro ETH_IN_FIFO_STATS_EN enables the drop/error counters; when it
// is undefined both counters read constant zero.
module eth_in_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_sop,
  input  logic        s_eop,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid,
  input  logic        stall,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t DepthP = ptr_t'(DEPTH);
  localparam ptr_t PtrOne = ptr_t'(1);

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} state_e;

  state_e      state_q, state_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        commit_q, commit_d;
  ptr_t        rd_ptr_q;

  // Each entry is {sop, eop, data}.
  logic [33:0] mem_q [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          drop_inc;
  logic          err_inc;
  logic          take;
  ptr_t          base;
  ptr_t          occ;

  logic [31:0] out_data_q;
  logic        out_sop_q;
  logic        out_eop_q;
  logic        out_valid_q;
  logic        out_en;
  logic        load;
  logic [33:0] rd_word;

  // Write-side FSM state and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      commit_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
    end
  end

  // Next-state: frame accept, commit, rollback on error or overflow.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    commit_d  = commit_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q[AW-1:0];
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    take      = 1'b0;
    base      = wr_ptr_q;
    occ       = '0;
    if (s_valid) begin
      unique case (state_q)
        StIdle: begin
          if (s_sop) take = 1'b1;
          else       err_inc = 1'b1;
        end
        StFrame: begin
          take = 1'b1;
          if (s_sop) begin
            // Unterminated frame: discard it and restart at the committed point.
            err_inc = 1'b1;
            base    = commit_q;
          end
        end
        StDrop: begin
          if (s_sop) begin
            take    = 1'b1;
            err_inc = 1'b1;
          end else if (s_eop) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (take) begin
        // Occupancy counts uncommitted words; same-cycle pops are not credited.
        occ = base - rd_ptr_q;
        if (occ == DepthP) begin
          wr_ptr_d = commit_q;
          drop_inc = 1'b1;
          state_d  = s_eop ? StIdle : StDrop;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = base[AW-1:0];
          wr_ptr_d  = base + PtrOne;
          if (s_eop) begin
            commit_d = base + PtrOne;
            state_d  = StIdle;
          end else begin
            state_d  = StFrame;
          end
        end
      end
    end
  end

  // Frame storage; contents are never cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= {s_sop, s_eop, s_data};
  end

  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  assign out_en  = !out_valid_q || !stall;
  assign load    = out_en && (rd_ptr_q != commit_q);

  // Registered output stage: load a committed word when free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      rd_ptr_q    <= rd_ptr_q + PtrOne;
      out_data_q  <= rd_word[31:0];
      out_sop_q   <= rd_word[33];
      out_eop_q   <= rd_word[32];
      out_valid_q <= 1'b1;
    end else if (out_en) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_valid = out_valid_q;

`ifdef ETH_IN_FIFO_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] err_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (err_inc && (err_cnt_q != 16'hFFFF))   err_cnt_q  <= err_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = drop_inc ^ err_inc;
  assign drop_cnt     = '0;
  assign err_cnt      = '0;
`endif

endmodule
